// File: rtl/ram32_client_ctrl_pkg.sv
// Shared types and helpers for the 32-entry 64-bit 1RW1R register RAM client controller.
// Holds the data geometry, the controller state encoding and the byte-lane merge.
package ram32_client_ctrl_pkg;

   localparam int RAM_DATA_W = 64;
   localparam int RAM_BYTES  = 8;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_t;

   // Byte lanes with sel set come from new_data, the rest from old_data.
   function automatic logic [RAM_DATA_W-1:0] byte_merge(
      input logic [RAM_BYTES-1:0]  sel,
      input logic [RAM_DATA_W-1:0] new_data,
      input logic [RAM_DATA_W-1:0] old_data
   );
      logic [RAM_DATA_W-1:0] merged;
      merged = old_data;
      for (int i = 0; i < RAM_BYTES; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_data[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram32_client_ctrl.sv
// Requester-side controller for the 1RW1R register RAM macro: zero-fills the array after
// reset, then maps write/read requests onto macro ports 0/1 with a same-address read bypass.
module ram32_client_ctrl
   import ram32_client_ctrl_pkg::*;
#(
   parameter int BITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [BITS-1:0]       wr_addr,
   input  logic [RAM_BYTES-1:0]  wr_sel,
   input  logic [RAM_DATA_W-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [BITS-1:0]       rd_addr,
   output logic                  rd_resp_valid,
   output logic [RAM_DATA_W-1:0] rd_resp_data,
   output logic                  init_done,
   output logic                  ram_en0,
   output logic [BITS-1:0]       ram_a0,
   output logic [RAM_BYTES-1:0]  ram_we0,
   output logic [RAM_DATA_W-1:0] ram_di0,
   output logic                  ram_en1,
   output logic [BITS-1:0]       ram_a1,
   input  logic [RAM_DATA_W-1:0] ram_do1
);

   // Handshake: a request transfers in any cycle where valid & ready are both high.
   // Ready depends only on state (never on valid); the response has no backpressure.
   ctrl_state_t           state, state_n;
   logic [BITS-1:0]       count, count_n;
   logic                  wr_acc, rd_acc;
   logic                  byp_hit;
   logic [RAM_BYTES-1:0]  byp_sel;
   logic [RAM_DATA_W-1:0] byp_data;

   assign wr_acc = (state == ST_RUN) && wr_valid;
   assign rd_acc = (state == ST_RUN) && rd_valid;

   always_comb begin
      state_n  = state;
      count_n  = count;
      wr_ready = 1'b0;
      rd_ready = 1'b0;
      ram_en0  = 1'b0;
      ram_a0   = '0;
      ram_we0  = '0;
      ram_di0  = '0;
      ram_en1  = 1'b0;
      ram_a1   = '0;
      case (state)
         ST_INIT: begin
            ram_en0 = 1'b1;
            ram_a0  = count;
            ram_we0 = '1;
            count_n = count + 1'b1;
            if (count == {BITS{1'b1}}) state_n = ST_RUN;
         end
         ST_RUN: begin
            wr_ready = 1'b1;
            rd_ready = 1'b1;
            if (wr_valid) begin
               ram_en0 = 1'b1;
               ram_a0  = wr_addr;
               ram_we0 = wr_sel;
               ram_di0 = wr_data;
            end
            if (rd_valid) begin
               ram_en1 = 1'b1;
               ram_a1  = rd_addr;
            end
         end
         default: state_n = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_INIT;
         count         <= '0;
         init_done     <= 1'b0;
         rd_resp_valid <= 1'b0;
         byp_hit       <= 1'b0;
         byp_sel       <= '0;
         byp_data      <= '0;
      end else begin
         state         <= state_n;
         count         <= count_n;
         if (state == ST_INIT && state_n == ST_RUN) init_done <= 1'b1;
         rd_resp_valid <= rd_acc;
         // The macro returns pre-write data on a same-address collision, so keep the write.
         byp_hit       <= wr_acc && rd_acc && (wr_addr == rd_addr);
         byp_sel       <= wr_sel;
         byp_data      <= wr_data;
      end
   end

   assign rd_resp_data = rd_resp_valid
                         ? byte_merge(byp_hit ? byp_sel : '0, byp_data, ram_do1)
                         : '0;

endmodule

// File: tb/tb_ram32_client_ctrl.sv
// Self-checking bench for ram32_client_ctrl with a behavioural 1RW1R macro attached.
// A reference memory plus an expected-response queue predicts every macro-port and response value.
module tb_ram32_client_ctrl;

  localparam int BITS  = 5;
  localparam int DEPTH = 1 << BITS;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_sel;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  rd_addr;
  logic        rd_resp_valid;
  logic [63:0] rd_resp_data;
  logic        init_done;
  logic        ram_en0;
  logic [4:0]  ram_a0;
  logic [7:0]  ram_we0;
  logic [63:0] ram_di0;
  logic        ram_en1;
  logic [4:0]  ram_a1;
  logic [63:0] ram_do1;

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  logic [63:0] m_mem [DEPTH];
  int          m_cnt;
  bit          m_run;
  logic [63:0] exp_q [$];

  // behavioural macro: read port returns pre-write contents on a collision
  logic [63:0] macro_mem [DEPTH];

  ram32_client_ctrl #(.BITS(BITS)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .init_done(init_done),
    .ram_en0(ram_en0), .ram_a0(ram_a0), .ram_we0(ram_we0), .ram_di0(ram_di0),
    .ram_en1(ram_en1), .ram_a1(ram_a1), .ram_do1(ram_do1)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) macro_mem[i] = {$urandom, $urandom};
    ram_do1 = {$urandom, $urandom};
  end

  always @(posedge clk) begin
    if (ram_en1) ram_do1 <= macro_mem[ram_a1];
    if (ram_en0)
      for (int b = 0; b < 8; b++)
        if (ram_we0[b]) macro_mem[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sel_mask(input logic [7:0] sel);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (sel[b]) m = m | (64'hFF << (8 * b));
    return m;
  endfunction

  // driver: one clock cycle of stimulus, checked before and after the edge
  task automatic tick(input bit r, input bit wv, input logic [4:0] wa, input logic [7:0] ws,
                      input logic [63:0] wd, input bit rv, input logic [4:0] ra);
    logic [63:0] mask;
    bit          exp_v;
    logic [63:0] exp_d;
    @(negedge clk);
    rst = r; wr_valid = wv; wr_addr = wa; wr_sel = ws; wr_data = wd; rd_valid = rv; rd_addr = ra;
    #1;
    if (!r) begin
      if (m_run) begin
        check("run_wr_ready", 64'(wr_ready), 64'd1);
        check("run_rd_ready", 64'(rd_ready), 64'd1);
        check("run_en0", 64'(ram_en0), 64'(wv));
        check("run_a0",  64'(ram_a0),  wv ? 64'(wa) : 64'd0);
        check("run_we0", 64'(ram_we0), wv ? 64'(ws) : 64'd0);
        check("run_di0", ram_di0,      wv ? wd : 64'd0);
        check("run_en1", 64'(ram_en1), 64'(rv));
        check("run_a1",  64'(ram_a1),  rv ? 64'(ra) : 64'd0);
      end else begin
        check("init_wr_ready", 64'(wr_ready), 64'd0);
        check("init_rd_ready", 64'(rd_ready), 64'd0);
        check("init_en0", 64'(ram_en0), 64'd1);
        check("init_a0",  64'(ram_a0),  64'(m_cnt));
        check("init_we0", 64'(ram_we0), 64'hFF);
        check("init_di0", ram_di0,      64'd0);
        check("init_en1", 64'(ram_en1), 64'd0);
      end
    end
    exp_v = 1'b0;
    if (r) begin
      m_cnt = 0;
      m_run = 1'b0;
      exp_q.delete();
    end else if (!m_run) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else begin
      if (wv) begin
        mask = sel_mask(ws);
        m_mem[wa] = (m_mem[wa] & ~mask) | (wd & mask);
      end
      // a read sees the write accepted in the same cycle
      if (rv) begin
        exp_v = 1'b1;
        exp_q.push_back(m_mem[ra]);
      end
    end
    @(posedge clk);
    #1;
    check("resp_valid", 64'(rd_resp_valid), 64'(exp_v));
    exp_d = (exp_v && exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    check("resp_data", rd_resp_data, exp_d);
    check("init_done", 64'(init_done), 64'(m_run));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b0, 5'd0);
  endtask

  task automatic rand_tick();
    logic [4:0] wa, ra;
    wa = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, DEPTH - 1));
    ra = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, DEPTH - 1));
    tick(1'b0, 1'($urandom_range(0, 1)), wa, 8'($urandom_range(0, 255)), {$urandom, $urandom},
         1'($urandom_range(0, 1)), ra);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_sel = '0; wr_data = '0; rd_valid = 1'b0; rd_addr = '0;
    m_cnt = 0; m_run = 1'b0;
    tick(1'b1, 1'b0, 5'd0, 8'h00, 64'd0, 1'b0, 5'd0);
    tick(1'b1, 1'b0, 5'd0, 8'h00, 64'd0, 1'b0, 5'd0);
    // zero-fill, with requests offered that must be ignored
    for (int i = 0; i < DEPTH; i++) rand_tick();

    // plain write then read
    tick(1'b0, 1'b1, 5'd5, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 5'd0);
    tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'd5);
    // partial write colliding with a read of the same entry
    tick(1'b0, 1'b1, 5'd7, 8'hFF, 64'h1111111111111111, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 5'd7, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b1, 5'd7);
    tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'd7);
    // different addresses in the same cycle
    tick(1'b0, 1'b1, 5'd3, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b1, 5'd4);
    // zero byte-enable write
    tick(1'b0, 1'b1, 5'd5, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5'd5);
    // back-to-back reads
    tick(1'b0, 1'b1, 5'd0, 8'hFF, 64'd10, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 5'd1, 8'hFF, 64'd11, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 5'd2, 8'hFF, 64'd12, 1'b0, 5'd0);
    tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'd0);
    tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'd1);
    tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'd2);
    idle();

    for (int i = 0; i < 300; i++) rand_tick();

    // reset with a read in flight, then reset again mid zero-fill
    tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'd1);
    tick(1'b1, 1'b1, 5'd2, 8'hFF, 64'h55, 1'b1, 5'd2);
    for (int i = 0; i < 17; i++) idle();
    tick(1'b1, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'd9);
    for (int i = 0; i < DEPTH; i++) idle();
    // every entry must read back as zero
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b0, 5'd0, 8'h00, 64'd0, 1'b1, 5'(i));
    for (int i = 0; i < 200; i++) rand_tick();
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
